// File: rtl/stream_arb_pkg.sv
// Shared widths, helper and index type for the round-robin stream arbiter.
// The optional packet lock is compiled in with ARB_LOCK_EN.
package stream_arb_pkg;

   // Index width that never collapses to zero bits.
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   localparam int DEFAULT_N   = 4;
   localparam int DEFAULT_L   = 8;
   localparam int DEFAULT_IDW = clog2_min1(DEFAULT_N);

   typedef logic [DEFAULT_IDW-1:0] gnt_idx_t;

endpackage

// File: rtl/stream_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: the first request at or after (last+1) mod N wins.
// Implemented as rotate, priority encode, un-rotate.
module rr_pick
   import stream_arb_pkg::*;
#(
   parameter int N   = DEFAULT_N,
   parameter int IDW = clog2_min1(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] last,
   output logic           gnt_valid,
   output logic [IDW-1:0] gnt_idx
);

   logic [IDW:0]   start;
   logic [2*N-1:0] req_dbl;
   logic [N-1:0]   req_rot;
   logic [IDW:0]   enc;
   logic [IDW:0]   sum;

   always_comb begin
      start = {1'b0, last} + (IDW+1)'(1);
      if (start >= (IDW+1)'(N)) begin
         start = '0;
      end
      req_dbl = {req, req};
      req_rot = N'(req_dbl >> start);

      gnt_valid = |req_rot;
      enc = '0;
      for (int i = N-1; i >= 0; i--) begin
         if (req_rot[i]) begin
            enc = (IDW+1)'(i);
         end
      end

      // Both terms are below N, so one conditional subtract is a full modulo.
      sum = enc + start;
      if (sum >= (IDW+1)'(N)) begin
         sum = sum - (IDW+1)'(N);
      end
      gnt_idx = IDW'(sum);
   end

endmodule

// File: rtl/stream_rr_arbiter.sv
// N-to-1 round-robin valid/ready arbiter with one registered output stage.
// Define ARB_LOCK_EN to keep multi-beat packets (in_last/out_last) unbroken.
module stream_rr_arbiter
   import stream_arb_pkg::*;
#(
   parameter int N   = DEFAULT_N,
   parameter int L   = DEFAULT_L,
   parameter int IDW = clog2_min1(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   in_valid,
   input  logic [N*L-1:0] in_data,
   output logic [N-1:0]   in_ready,
`ifdef ARB_LOCK_EN
   input  logic [N-1:0]   in_last,
   output logic           out_last,
`endif
   output logic           out_valid,
   output logic [L-1:0]   out_data,
   output logic [IDW-1:0] out_id,
   input  logic           out_ready
);

   logic           out_valid_q, out_valid_d;
   logic [L-1:0]   out_data_q,  out_data_d;
   logic [IDW-1:0] out_id_q,    out_id_d;
   logic [IDW-1:0] last_q,      last_d;
   logic           load;
   logic           xfer;
   logic           pick_valid;
   logic [IDW-1:0] pick_idx;
   logic           grant_valid;
   logic [IDW-1:0] grant_idx;
   logic           grant_held;
`ifdef ARB_LOCK_EN
   logic           locked_q,   locked_d;
   logic [IDW-1:0] lock_id_q,  lock_id_d;
   logic           out_last_q, out_last_d;
`endif

   rr_pick #(
      .N   (N),
      .IDW (IDW)
   ) u_pick (
      .req       (in_valid),
      .last      (last_q),
      .gnt_valid (pick_valid),
      .gnt_idx   (pick_idx)
   );

   always_comb begin
      load        = !out_valid_q || out_ready;
      grant_valid = pick_valid;
      grant_idx   = pick_idx;
      grant_held  = 1'b0;
`ifdef ARB_LOCK_EN
      // A locked packet owns the channel even while its source idles.
      if (locked_q) begin
         grant_idx   = lock_id_q;
         grant_valid = in_valid[lock_id_q];
         grant_held  = 1'b1;
      end
`endif
      in_ready = '0;
      if (load && (grant_valid || grant_held)) begin
         in_ready[grant_idx] = 1'b1;
      end
      xfer = load && grant_valid;

      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_id_d    = out_id_q;
      last_d      = last_q;
`ifdef ARB_LOCK_EN
      locked_d    = locked_q;
      lock_id_d   = lock_id_q;
      out_last_d  = out_last_q;
`endif
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = in_data[int'(grant_idx)*L +: L];
         out_id_d    = grant_idx;
         last_d      = grant_idx;
`ifdef ARB_LOCK_EN
         out_last_d  = in_last[grant_idx];
         locked_d    = !in_last[grant_idx];
         lock_id_d   = grant_idx;
`endif
      end else if (load) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= '0;
         last_q      <= IDW'(N-1);
`ifdef ARB_LOCK_EN
         locked_q    <= 1'b0;
         lock_id_q   <= '0;
         out_last_q  <= 1'b0;
`endif
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_id_q    <= out_id_d;
         last_q      <= last_d;
`ifdef ARB_LOCK_EN
         locked_q    <= locked_d;
         lock_id_q   <= lock_id_d;
         out_last_q  <= out_last_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_id    = out_id_q;
`ifdef ARB_LOCK_EN
   assign out_last  = out_last_q;
`endif

endmodule
